// File: rtl/msb_req_scheduler_pkg.sv
// Shared constants for the strict-priority request scheduler.
//   DEF_N     : default number of request sources
//   DEF_N_LOG : default grant index width, log2(DEF_N)
package msb_req_scheduler_pkg;
  localparam int DEF_N     = 64;
  localparam int DEF_N_LOG = 6;
endpackage

// File: rtl/msb_req_scheduler_idx_msb_one.sv
// idx_msb_one: combinational most-significant-one encoder.
// Ports:
//   vec : I-bit input vector
//   idx : index of the highest set bit of vec. It reads 0 both when vec is
//         zero and when only bit 0 is set, so the caller must qualify it
//         with |vec.
module idx_msb_one #(
  parameter int I     = 64,
  parameter int I_log = 6
) (
  input  logic [I-1:0]     vec,
  output logic [I_log-1:0] idx
);
  always_comb begin
    idx = '0;
    // Ascending scan: the last hit is the highest set bit.
    for (int unsigned i = 0; i < I; i++) begin
      if (vec[i]) idx = I_log'(i);
    end
  end
endmodule

// File: rtl/msb_req_scheduler.sv
// msb_req_scheduler: collects one-bit requests into a pending register and
// issues the highest-index pending, enabled request over valid/ready.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   set_i         : per-source request pulses, OR'd into pending
//   mask_i        : per-source enable (masked bits stay pending)
//   flush_i       : clears pending (set_i still captured) and drops grant
//   grant_v_o     : grant valid (registered)
//   grant_idx_o   : granted source index (registered)
//   grant_ready_i : consumer accepts when high together with grant_v_o
//   pending_o     : pending register
module msb_req_scheduler
  import msb_req_scheduler_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int N_LOG = DEF_N_LOG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     set_i,
  input  logic [N-1:0]     mask_i,
  input  logic             flush_i,
  output logic             grant_v_o,
  output logic [N_LOG-1:0] grant_idx_o,
  input  logic             grant_ready_i,
  output logic [N-1:0]     pending_o
);

  function automatic logic [N-1:0] onehot(input logic [N_LOG-1:0] sel);
    logic [N-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

  logic             accept;
  logic             hold;
  logic [N-1:0]     grant_oh;
  logic [N-1:0]     acc_oh;
  logic [N-1:0]     hold_oh;
  logic [N-1:0]     cand;
  logic             cand_v;
  logic [N_LOG-1:0] cand_idx;

  always_comb begin
    accept   = grant_v_o & grant_ready_i;
    hold     = grant_v_o & ~grant_ready_i;
    grant_oh = onehot(grant_idx_o);
    acc_oh   = accept ? grant_oh : '0;
    hold_oh  = hold ? grant_oh : '0;
    // The outstanding index is excluded whether it is being accepted or held,
    // so the same source is never issued twice for one request.
    cand     = pending_o & mask_i & ~acc_oh & ~hold_oh;
    cand_v   = |cand;
  end

  idx_msb_one #(
    .I    (N),
    .I_log(N_LOG)
  ) u_enc (
    .vec(cand),
    .idx(cand_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_o   <= '0;
      grant_v_o   <= 1'b0;
      grant_idx_o <= '0;
    end else begin
      // set_i is OR'd last, so a same-cycle set beats the accept clear.
      if (flush_i) pending_o <= set_i;
      else         pending_o <= (pending_o & ~acc_oh) | set_i;

      if (flush_i) begin
        grant_v_o <= 1'b0;
      end else if (!hold) begin
        grant_v_o <= cand_v;
        if (cand_v) grant_idx_o <= cand_idx;
      end
    end
  end

endmodule

// File: tb/tb_msb_req_scheduler.sv
module tb_msb_req_scheduler;
  localparam int N     = 64;
  localparam int N_LOG = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     set_i;
  logic [N-1:0]     mask_i;
  logic             flush_i;
  logic             grant_v_o;
  logic [N_LOG-1:0] grant_idx_o;
  logic             grant_ready_i;
  logic [N-1:0]     pending_o;

  int checks = 0;
  int errors = 0;

  msb_req_scheduler #(.N(N), .N_LOG(N_LOG)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_i        (set_i),
    .mask_i       (mask_i),
    .flush_i      (flush_i),
    .grant_v_o    (grant_v_o),
    .grant_idx_o  (grant_idx_o),
    .grant_ready_i(grant_ready_i),
    .pending_o    (pending_o)
  );

  always #5 clk = ~clk;

  // Reference model: set of pending sources plus the outstanding grant.
  bit [63:0] m_pend;
  bit        m_v;
  int        m_idx;

  function automatic int highest(input bit [63:0] c);
    for (int i = 63; i >= 0; i--) if (c[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_v    = 1'b0;
    m_idx  = 0;
  endtask

  task automatic model_step();
    bit [63:0] c;
    bit [63:0] p;
    bit        acc;
    int        top;
    acc = m_v && grant_ready_i;
    c   = m_pend & mask_i;
    if (m_v) c[m_idx] = 1'b0;
    p = m_pend;
    if (acc) p[m_idx] = 1'b0;
    p = p | set_i;
    if (flush_i) p = set_i;
    if (flush_i) begin
      m_v = 1'b0;
    end else if (!(m_v && !grant_ready_i)) begin
      top = highest(c);
      m_v = (top >= 0);
      if (top >= 0) m_idx = top;
    end
    m_pend = p;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] s, input logic [63:0] m, input logic f, input logic r);
    set_i = s; mask_i = m; flush_i = f; grant_ready_i = r;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, " pend"}, pending_o, m_pend);
    chk({tag, " valid"}, 64'(grant_v_o), 64'(m_v));
    chk({tag, " idx"}, 64'(grant_idx_o), 64'(m_idx));
  endtask

  function automatic logic [63:0] b(input int i);
    logic [63:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  typedef struct {
    logic [63:0] set;
    logic        ready;
    logic [63:0] exp_pend;
    logic        exp_v;
    int          exp_idx;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [63:0] ones;
    ones = '1;

    tbl[0] = '{b(5),                 1'b1, b(5),                 1'b0, 0};
    tbl[1] = '{64'd0,                1'b1, b(5),                 1'b1, 5};
    tbl[2] = '{64'd0,                1'b1, 64'd0,                1'b0, 5};
    tbl[3] = '{b(63) | b(10) | b(0), 1'b1, b(63) | b(10) | b(0), 1'b0, 5};
    tbl[4] = '{64'd0,                1'b1, b(63) | b(10) | b(0), 1'b1, 63};
    tbl[5] = '{64'd0,                1'b1, b(10) | b(0),         1'b1, 10};
    tbl[6] = '{64'd0,                1'b1, b(0),                 1'b1, 0};
    tbl[7] = '{64'd0,                1'b1, 64'd0,                1'b0, 0};

    rst = 1'b1;
    drive('0, ones, 1'b0, 1'b0);
    model_reset();
    #12;
    chk("reset pend", pending_o, 64'd0);
    chk("reset valid", 64'(grant_v_o), 64'd0);
    chk("reset idx", 64'(grant_idx_o), 64'd0);
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // Table: single request latency, then 63/10/0 back-to-back.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].set, ones, 1'b0, tbl[i].ready);
      tick("tbl");
      chk($sformatf("tbl%0d pend", i), pending_o, tbl[i].exp_pend);
      chk($sformatf("tbl%0d valid", i), 64'(grant_v_o), 64'(tbl[i].exp_v));
      chk($sformatf("tbl%0d idx", i), 64'(grant_idx_o), 64'(tbl[i].exp_idx));
    end

    // Hold under back-pressure while a higher-than-3 request arrives.
    drive(b(40) | b(3), ones, 1'b0, 1'b0); tick("hold");
    drive('0, ones, 1'b0, 1'b0);           tick("hold");
    chk("hold first idx", 64'(grant_idx_o), 64'd40);
    drive(b(50), ones, 1'b0, 1'b0);        tick("hold");
    drive('0, ones, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      chk("hold stable idx", 64'(grant_idx_o), 64'd40);
    end
    drive('0, ones, 1'b0, 1'b1);
    tick("hold"); chk("order 2nd", 64'(grant_idx_o), 64'd50);
    tick("hold"); chk("order 3rd", 64'(grant_idx_o), 64'd3);
    tick("hold"); chk("order done", 64'(grant_v_o), 64'd0);

    // Masked source stays pending, granted once re-enabled.
    drive(b(20) | b(7), ~b(20), 1'b0, 1'b1); tick("mask");
    drive('0, ~b(20), 1'b0, 1'b1);           tick("mask");
    chk("mask grants 7", 64'(grant_idx_o), 64'd7);
    tick("mask");
    chk("mask 20 pending", pending_o, b(20));
    chk("mask no grant", 64'(grant_v_o), 64'd0);
    drive('0, ones, 1'b0, 1'b1);             tick("mask");
    chk("unmask grants 20", 64'(grant_idx_o), 64'd20);
    tick("mask");

    // Re-request in the accept cycle keeps the bit pending.
    drive(b(12), ones, 1'b0, 1'b0); tick("reset12");
    drive('0, ones, 1'b0, 1'b0);    tick("reset12");
    tick("reset12");
    drive(b(12), ones, 1'b0, 1'b1); tick("reset12");
    chk("reset12 still pending", pending_o, b(12));
    drive('0, ones, 1'b0, 1'b1);    tick("reset12");
    chk("reset12 regrant v", 64'(grant_v_o), 64'd1);
    chk("reset12 regrant idx", 64'(grant_idx_o), 64'd12);
    tick("reset12");

    // Flush drops the held grant and keeps the same-cycle set.
    drive(b(30) | b(2), ones, 1'b0, 1'b0); tick("flush");
    drive('0, ones, 1'b0, 1'b0);           tick("flush");
    chk("flush held 30", 64'(grant_idx_o), 64'd30);
    drive(b(9), ones, 1'b1, 1'b0);         tick("flush");
    chk("flush valid", 64'(grant_v_o), 64'd0);
    chk("flush pend", pending_o, b(9));
    drive('0, ones, 1'b0, 1'b0);           tick("flush");
    chk("flush regrant", 64'(grant_idx_o), 64'd9);

    // Asynchronous reset while a grant is outstanding.
    #2 rst = 1'b1;
    #1;
    chk("async pend", pending_o, 64'd0);
    chk("async valid", 64'(grant_v_o), 64'd0);
    chk("async idx", 64'(grant_idx_o), 64'd0);
    model_reset();
    #2 rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom},
            ~({$urandom, $urandom} & {$urandom, $urandom}),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) != 0));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
